// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up counter and its prescaler.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package counter_pkg;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_PRESCALE = 1;

  // Bits needed to hold a prescaler phase in 0..prescale-1; never below 1.
  function automatic int presc_w(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits tick on every PRESCALE-th enabled cycle (every enabled cycle when PRESCALE=1).
// Latency: tick is combinational from en and the registered phase; phase updates next posedge.
// Backpressure: none; the phase holds while en=0, and clr or rst returns it to 0.
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = presc_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // The last phase of the cycle is the one that lets the counter step.
  assign tick = en && (phase == LAST);

  // Phase advances on enabled cycles and wraps after the last phase.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      if (phase == LAST) phase <= '0;
      else               phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/up_counter_mod.sv
// Up counter 0..max_val with prescaler, synchronous load, one-cycle wrap pulse and sticky overflow.
// Latency: count, tc and ovf are registered and update one clk edge after the qualifying inputs.
// Backpressure: none; en=0 holds count and prescaler phase, and load overrides stepping.
module up_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic tick;
  logic step;
  logic wrap;

  // A load restarts the prescaler so the next step comes a full period later.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // Load outranks stepping; a count at or above the limit (e.g. after an
  // out-of-range load) wraps to 0 on its next step.
  assign step = tick && !load;
  assign wrap = step && (count >= max_val);

  // Counter value: reset > load > step > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step) begin
      if (wrap) count <= '0;
      else      count <= count + 1'b1;
    end
  end

  // Wrap pulse: high only in the cycle that first shows 0 after a wrap.
  always_ff @(posedge clk) begin
    if (rst) tc <= 1'b0;
    else     tc <= wrap;
  end

  // Sticky overflow: a wrap wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (wrap)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench for up_counter_mod: PRESCALE=1 and PRESCALE=3 instances share stimulus.
// Expected outputs are queued at drive time and checked one edge later.
// Inputs are driven on negedge, outputs sampled #1 after posedge.
module tb_up_counter_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] max_val;
  logic       clr_ovf;

  logic [2:0] count1, count3;
  logic       tc1, tc3, ovf1, ovf3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       sel;   // 0: PRESCALE=1 instance, 1: PRESCALE=3 instance
    logic [2:0] cnt;
    logic       tc;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  up_counter_mod #(.WIDTH(3), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .max_val(max_val), .clr_ovf(clr_ovf), .count(count1), .tc(tc1), .ovf(ovf1)
  );

  up_counter_mod #(.WIDTH(3), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .max_val(max_val), .clr_ovf(clr_ovf), .count(count3), .tc(tc3), .ovf(ovf3)
  );

  // Drive one cycle of inputs, queue the expected result, then compare after the edge.
  task automatic step(input logic sel, input logic r, input logic e, input logic l,
                      input logic [2:0] lv, input logic [2:0] mv, input logic c,
                      input logic [2:0] x_cnt, input logic x_tc, input logic x_ovf,
                      input string name);
    exp_t x;
    logic [2:0] o_cnt;
    logic       o_tc, o_ovf;
    @(negedge clk);
    rst = r; en = e; load = l; load_val = lv; max_val = mv; clr_ovf = c;
    x.sel = sel; x.cnt = x_cnt; x.tc = x_tc; x.ovf = x_ovf; x.name = name;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() == 1) else begin
      errors++;
      $error("FAIL %s scoreboard depth: got %0d expected 1", name, sb.size());
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      o_cnt = x.sel ? count3 : count1;
      o_tc  = x.sel ? tc3    : tc1;
      o_ovf = x.sel ? ovf3   : ovf1;
      checks++;
      assert (o_cnt === x.cnt) else begin
        errors++;
        $error("FAIL %s count: got %0d expected %0d", x.name, o_cnt, x.cnt);
      end
      checks++;
      assert (o_tc === x.tc) else begin
        errors++;
        $error("FAIL %s tc: got %b expected %b", x.name, o_tc, x.tc);
      end
      checks++;
      assert (o_ovf === x.ovf) else begin
        errors++;
        $error("FAIL %s ovf: got %b expected %b", x.name, o_ovf, x.ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; max_val = 3'd7; clr_ovf = 1'b0;

    // Reset for 10 cycles, then full run to 7 and wrap.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst = 1'b1;
    end
    step(0, 1, 1, 0, 0, 7, 0, 0, 0, 0, "reset");
    for (int i = 1; i <= 7; i++)
      step(0, 0, 1, 0, 0, 7, 0, 3'(i), 0, 0, "run7");
    step(0, 0, 1, 0, 0, 7, 0, 0, 1, 1, "wrap7");
    step(0, 0, 0, 0, 0, 7, 0, 0, 0, 1, "hold_after_wrap");

    // max_val=4: 1,2,3,4,0(tc),1.
    for (int i = 1; i <= 4; i++)
      step(0, 0, 1, 0, 0, 4, 0, 3'(i), 0, 1, "run4");
    step(0, 0, 1, 0, 0, 4, 0, 0, 1, 1, "wrap4");
    step(0, 0, 1, 0, 0, 4, 0, 1, 0, 1, "after_wrap4");
    step(0, 0, 0, 0, 0, 4, 0, 1, 0, 1, "hold_en0");

    // Clear coinciding with a wrap leaves ovf set; a later clear drops it.
    for (int i = 2; i <= 4; i++)
      step(0, 0, 1, 0, 0, 4, 0, 3'(i), 0, 1, "run_to_clr");
    step(0, 0, 1, 0, 0, 4, 1, 0, 1, 1, "clr_with_wrap");
    step(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, "clr_after_wrap");

    // Load above max_val, then a step wraps it to 0.
    step(0, 0, 0, 1, 6, 3, 0, 6, 0, 0, "load_over_max");
    step(0, 0, 1, 0, 0, 3, 0, 0, 1, 1, "wrap_from_load");

    // max_val=0 wraps on every step.
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "max0_a");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "max0_b");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "max0_clr");

    // Load outranks an enabled step; load keeps ovf; reset outranks everything.
    step(0, 0, 1, 1, 5, 0, 0, 5, 0, 0, "load_vs_step");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "wrap_from5");
    step(0, 0, 0, 1, 5, 7, 0, 5, 0, 1, "load_keeps_ovf");
    step(0, 1, 1, 1, 2, 7, 0, 0, 0, 0, "rst_over_load");

    // PRESCALE=3 instance: en pattern 1,1,0,1 steps on the 3rd enabled cycle.
    step(1, 1, 0, 0, 0, 7, 0, 0, 0, 0, "p3_reset");
    step(1, 0, 1, 0, 0, 7, 0, 0, 0, 0, "p3_en1");
    step(1, 0, 1, 0, 0, 7, 0, 0, 0, 0, "p3_en2");
    step(1, 0, 0, 0, 0, 7, 0, 0, 0, 0, "p3_hold");
    step(1, 0, 1, 0, 0, 7, 0, 1, 0, 0, "p3_en3");
    step(1, 0, 1, 0, 0, 7, 0, 1, 0, 0, "p3_en4");
    step(1, 0, 1, 0, 0, 7, 0, 1, 0, 0, "p3_en5");
    step(1, 0, 1, 0, 0, 7, 0, 2, 0, 0, "p3_en6");

    // Load mid-prescale restarts the phase.
    step(1, 0, 1, 0, 0, 7, 0, 2, 0, 0, "p3_mid");
    step(1, 0, 1, 1, 0, 7, 0, 0, 0, 0, "p3_load");
    step(1, 0, 1, 0, 0, 7, 0, 0, 0, 0, "p3_after_load1");
    step(1, 0, 1, 0, 0, 7, 0, 0, 0, 0, "p3_after_load2");
    step(1, 0, 1, 0, 0, 7, 0, 1, 0, 0, "p3_after_load3");

    // Reset mid-prescale restarts the phase.
    step(1, 0, 1, 0, 0, 7, 0, 1, 0, 0, "p3_mid2");
    step(1, 1, 1, 0, 0, 7, 0, 0, 0, 0, "p3_rst_mid");
    step(1, 0, 1, 0, 0, 7, 0, 0, 0, 0, "p3_after_rst1");
    step(1, 0, 1, 0, 0, 7, 0, 0, 0, 0, "p3_after_rst2");
    step(1, 0, 1, 0, 0, 7, 0, 1, 0, 0, "p3_after_rst3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_counter_mod.md
UP_COUNTER_MOD -- requirements
Module: up_counter_mod

Interface
REQ-001 Parameter WIDTH, default 3, counter width in bits (WIDTH >= 2).
REQ-002 Parameter PRESCALE, default 1, enabled clk cycles per count step (PRESCALE >= 1).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable; gates the prescaler and the counter.
REQ-006 load  input  1  synchronous load of load_val.
REQ-007 load_val  input  WIDTH  value loaded when load=1.
REQ-008 max_val  input  WIDTH  wrap limit; count runs 0..max_val.
REQ-009 clr_ovf  input  1  clears the sticky overflow flag.
REQ-010 count  output  WIDTH  registered counter value.
REQ-011 tc  output  1  registered one-cycle wrap pulse.
REQ-012 ovf  output  1  registered sticky wrap flag.

Function
REQ-013 Update priority SHALL be rst > load > step > hold.
REQ-014 A step SHALL occur on a posedge where en=1, load=0, rst=0 and the prescaler tick is 1.
REQ-015 Prescaler: PRESCALE=1 gives tick=1 on every enabled cycle; otherwise tick=1 on every PRESCALEth enabled cycle, with the prescaler holding while en=0.
REQ-016 On a step with count < max_val, count SHALL become count+1 (modulo 2^WIDTH).
REQ-017 On a step with count >= max_val, count SHALL become 0 and the wrap event SHALL fire.
REQ-018 tc SHALL be 1 for exactly the one cycle in which count first shows 0 after a wrap event, and 0 otherwise.
REQ-019 ovf SHALL be set by a wrap event and cleared by clr_ovf; simultaneous wrap and clr_ovf SHALL leave ovf=1.
REQ-020 load=1 SHALL set count=load_val unconditionally (including load_val > max_val), clear tc, reset the prescaler phase, and leave ovf unchanged.
REQ-021 max_val=0 SHALL hold count at 0 and fire a wrap event on every step.
REQ-022 A change of max_val SHALL take effect on the next step with no other side effect.
REQ-023 Latency: count, tc and ovf change one clk edge after the qualifying inputs.

Reset
REQ-024 While rst=1 at a posedge, count SHALL become 0, tc 0, ovf 0 and the prescaler phase 0.
REQ-025 Reset asserted mid-count or mid-prescale SHALL override every other input in that cycle.

Structure
REQ-026 The default WIDTH and PRESCALE constants and the prescaler-width function SHALL live in shared package counter_pkg.
REQ-027 The prescaler SHALL be the separate sub-module tick_gen (ports clk, rst, en, clr, tick).
REQ-028 There SHALL be no latches and no combinational paths from inputs to outputs.

Verification
REQ-029 Set rst=1 for 10 cycles and then rst=0 with en=1, max_val=7, PRESCALE=1 -> count runs 0,1,...,7,0; tc=1 only with the second 0; ovf=1 from then on.
REQ-030 Set max_val=4 and en=1 from count=0 -> count runs 0,1,2,3,4,0,1; tc pulses once per wrap.
REQ-031 Load with load_val=6 and max_val=3, then step -> count=6, then 0 with tc=1.
REQ-032 Set PRESCALE=3, max_val=7, toggle en 1,1,0,1 -> count increments only on the 3rd enabled cycle and holds while en=0.
REQ-033 Assert clr_ovf in the same cycle as a wrap -> ovf stays 1; assert clr_ovf on the next cycle -> ovf=0.
REQ-034 Assert rst=1 at count=5 together with load=1 and en=1 -> count=0, tc=0, ovf=0 on the next cycle.
